sram_load_sequencer: RTL and testbench

Parametrised next-generation SRAM load controller for the detection datapath. It loads the image once per detection run, then serves coefficient loads from any of NUM_COEF_BANKS banks on demand. It generates per-word SRAM addresses with a req/ack handshake, instead of pulsing a single start and waiting for a done. It sits between the detection control FSM and the SRAM interface. It reports image-loaded and coefficient-loaded events to the processing core.

---
 rtl/sram_seq_pkg.sv | 24 ++
 rtl/sram_word_counter.sv | 27 ++
 rtl/sram_load_sequencer.sv | 137 +++++++++++++
 tb/tb_sram_load_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_seq_pkg.sv
// Shared types and helpers for the SRAM load sequencer: state encoding,
// word-index width and the coefficient bank base-address calculation.
package sram_seq_pkg;

  localparam int IDX_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    IMG_XFER,
    IMG_DONE,
    COEF_IDLE,
    COEF_XFER,
    COEF_DONE,
    ERROR
  } seq_state_e;

  // First word address of a coefficient bank; callers truncate to their address width.
  function automatic logic [63:0] coef_bank_base(input logic [63:0] coef_base,
                                                 input logic [63:0] coef_words,
                                                 input logic [63:0] bank);
    return coef_base + bank * coef_words;
  endfunction

endpackage

// File: rtl/sram_word_counter.sv
// Word counter for one SRAM transfer: synchronous clear, enable, and a
// last-word flag compared against a runtime index limit.
module sram_word_counter
  import sram_seq_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             en,
  input  logic [IDX_W-1:0] last_idx,
  output logic [IDX_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == last_idx);

endmodule

// File: rtl/sram_load_sequencer.sv
// SRAM load sequencer: one image load per detection run, then on-demand
// coefficient bank loads, one word per req/ack. Optional macro: SRAM_TIMEOUT_EN.
module sram_load_sequencer
  import sram_seq_pkg::*;
#(
  parameter  int ADDR_W         = 16,
  parameter  int IMAGE_BASE     = 0,
  parameter  int IMAGE_WORDS    = 64,
  parameter  int COEF_BASE      = 256,
  parameter  int COEF_WORDS     = 16,
  parameter  int NUM_COEF_BANKS = 4,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int BANK_W         = (NUM_COEF_BANKS > 1) ? $clog2(NUM_COEF_BANKS) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_detecting,
  input  logic              request_coef,
  input  logic [BANK_W-1:0] coef_bank_sel,
  input  logic              done_processing,
  input  logic              sram_ack,
  output logic              sram_req,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              load_is_coef,
  output logic [IDX_W-1:0]  word_idx,
  output logic              image_loaded,
  output logic              coef_loaded,
  output logic              bad_bank,
  output logic              busy,
  output logic              error
);

  localparam int SUM_W = ADDR_W + BANK_W + IDX_W;
  localparam logic [IDX_W-1:0] IMG_LAST  = IDX_W'(IMAGE_WORDS - 1);
  localparam logic [IDX_W-1:0] COEF_LAST = IDX_W'(COEF_WORDS - 1);

  seq_state_e        state;
  logic [BANK_W-1:0] bank_q;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  last_idx;
  logic              last_word;
  logic              in_xfer;
  logic              bank_ok;
  logic              coef_go;
  logic              cnt_clr;
  logic              cnt_en;
  logic              tmo_hit;
  logic [SUM_W-1:0]  img_sum;
  logic [SUM_W-1:0]  coef_sum;

  assign in_xfer  = (state == IMG_XFER) || (state == COEF_XFER);
  assign bank_ok  = 32'(coef_bank_sel) < NUM_COEF_BANKS;
  assign coef_go  = (state == COEF_IDLE) && request_coef && bank_ok;
  assign cnt_clr  = ((state == IDLE) && start_detecting) || coef_go;
  assign cnt_en   = in_xfer && sram_ack && !last_word;
  assign last_idx = (state == COEF_XFER) ? COEF_LAST : IMG_LAST;

  sram_word_counter u_word_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .last_idx (last_idx),
    .count    (idx),
    .last     (last_word)
  );

`ifdef SRAM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Counter is zero whenever no word is outstanding, so entry to a transfer starts it fresh.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmo_cnt <= '0;
    end else if (!in_xfer || sram_ack) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = in_xfer && !sram_ack && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign error   = (state == ERROR);
`else
  // Without the timeout a transfer waits on ack indefinitely.
  assign tmo_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      bank_q <= '0;
    end else begin
      case (state)
        IDLE:      if (start_detecting) state <= IMG_XFER;
        IMG_XFER: begin
          if (sram_ack && last_word) state <= IMG_DONE;
          else if (tmo_hit)          state <= ERROR;
        end
        IMG_DONE:  state <= COEF_IDLE;
        COEF_IDLE: begin
          // request_coef outranks done_processing, even when its bank is rejected.
          if (coef_go) begin
            bank_q <= coef_bank_sel;
            state  <= COEF_XFER;
          end else if (!request_coef && done_processing) begin
            state <= IDLE;
          end
        end
        COEF_XFER: begin
          if (sram_ack && last_word) state <= COEF_DONE;
          else if (tmo_hit)          state <= ERROR;
        end
        COEF_DONE: state <= COEF_IDLE;
        ERROR:     if (done_processing) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign img_sum  = SUM_W'(IMAGE_BASE) + SUM_W'(idx);
  assign coef_sum = SUM_W'(coef_bank_base(64'(COEF_BASE), 64'(COEF_WORDS), 64'(bank_q)))
                  + SUM_W'(idx);

  assign sram_req     = in_xfer;
  assign busy         = in_xfer;
  assign load_is_coef = (state == COEF_XFER);
  assign image_loaded = (state == IMG_DONE);
  assign coef_loaded  = (state == COEF_DONE);
  assign bad_bank     = (state == COEF_IDLE) && request_coef && !bank_ok;
  assign word_idx     = in_xfer ? idx : '0;
  assign sram_addr    = (state == IMG_XFER)  ? ADDR_W'(img_sum)  :
                        (state == COEF_XFER) ? ADDR_W'(coef_sum) : '0;

endmodule

// File: tb/tb_sram_load_sequencer.sv
// Directed bench for sram_load_sequencer: word scoreboard on every requested
// word, plus direct checks of pulses, priority, reset and the ack wait/timeout.
module tb_sram_load_sequencer;

  localparam int ADDR_W         = 16;
  localparam int IMAGE_BASE     = 'h40;
  localparam int IMAGE_WORDS    = 4;
  localparam int COEF_BASE      = 'h100;
  localparam int COEF_WORDS     = 16;
  localparam int NUM_COEF_BANKS = 3;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int BANK_W         = 2;
  localparam int W              = 33;

  logic              clk;
  logic              n_rst;
  logic              start_detecting;
  logic              request_coef;
  logic [BANK_W-1:0] coef_bank_sel;
  logic              done_processing;
  logic              sram_ack;
  logic              sram_req;
  logic [ADDR_W-1:0] sram_addr;
  logic              load_is_coef;
  logic [15:0]       word_idx;
  logic              image_loaded;
  logic              coef_loaded;
  logic              bad_bank;
  logic              busy;
  logic              error;

  int tests_run    = 0;
  int tests_failed = 0;
  int img_pulses   = 0;
  int coef_pulses  = 0;
  int bad_pulses   = 0;
  int exp_img      = 0;
  int exp_coef     = 0;
  int cyc;
  int snap;

  logic [W-1:0] exp_q[$];

  sram_load_sequencer #(
    .ADDR_W         (ADDR_W),
    .IMAGE_BASE     (IMAGE_BASE),
    .IMAGE_WORDS    (IMAGE_WORDS),
    .COEF_BASE      (COEF_BASE),
    .COEF_WORDS     (COEF_WORDS),
    .NUM_COEF_BANKS (NUM_COEF_BANKS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .start_detecting (start_detecting),
    .request_coef    (request_coef),
    .coef_bank_sel   (coef_bank_sel),
    .done_processing (done_processing),
    .sram_ack        (sram_ack),
    .sram_req        (sram_req),
    .sram_addr       (sram_addr),
    .load_is_coef    (load_is_coef),
    .word_idx        (word_idx),
    .image_loaded    (image_loaded),
    .coef_loaded     (coef_loaded),
    .bad_bank        (bad_bank),
    .busy            (busy),
    .error           (error)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every requested word must match the front of exp_q; acked words are popped.
  always @(negedge clk) begin
    if (n_rst) begin
      if (image_loaded) img_pulses++;
      if (coef_loaded)  coef_pulses++;
      if (bad_bank)     bad_pulses++;
      if (sram_req) begin
        chk("req_has_expected_word", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          chk(sram_ack ? "word_acked" : "word_held",
              64'({load_is_coef, word_idx, sram_addr}), 64'(exp_q[0]));
          if (sram_ack) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Driver tasks
  task automatic push_image();
    for (int i = 0; i < IMAGE_WORDS; i++)
      exp_q.push_back({1'b0, 16'(i), 16'(IMAGE_BASE + i)});
  endtask

  task automatic drain(input string tag, input int mode, output int cycles);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 200) begin
      case (mode)
        0:       sram_ack = 1'b1;
        1:       sram_ack = cycles[0];
        default: sram_ack = 1'($urandom_range(0, 1));
      endcase
      step();
      cycles++;
    end
    sram_ack = 1'b0;
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic finish_image(input string tag, input int mode);
    int n;
    drain(tag, mode, n);
    if (mode == 0) chk({tag, "_cycles"}, 64'(n), 64'(IMAGE_WORDS));
    chk({tag, "_loaded_pulse"}, 64'(image_loaded), 64'd1);
    chk({tag, "_not_busy"}, 64'(busy), 64'd0);
    exp_img++;
    step();
    chk({tag, "_loaded_low"}, 64'(image_loaded), 64'd0);
  endtask

  task automatic load_image(input string tag, input int mode);
    push_image();
    start_detecting = 1'b1;
    step();
    start_detecting = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_first_idx"}, 64'(word_idx), 64'd0);
    finish_image(tag, mode);
  endtask

  task automatic load_coef(input string tag, input int bank, input int mode, input bit with_done);
    int n;
    for (int i = 0; i < COEF_WORDS; i++)
      exp_q.push_back({1'b1, 16'(i), 16'(COEF_BASE + bank * COEF_WORDS + i)});
    request_coef    = 1'b1;
    coef_bank_sel   = BANK_W'(bank);
    done_processing = with_done;
    step();
    request_coef    = 1'b0;
    done_processing = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_is_coef"}, 64'(load_is_coef), 64'd1);
    drain(tag, mode, n);
    if (mode == 0) chk({tag, "_cycles"}, 64'(n), 64'(COEF_WORDS));
    if (mode == 1) chk({tag, "_cycles"}, 64'(n), 64'(2 * COEF_WORDS));
    chk({tag, "_loaded_pulse"}, 64'(coef_loaded), 64'd1);
    exp_coef++;
    step();
    chk({tag, "_loaded_low"}, 64'(coef_loaded), 64'd0);
  endtask

  initial begin
    n_rst = 1'b0;
    start_detecting = 1'b0;
    request_coef = 1'b0;
    coef_bank_sel = '0;
    done_processing = 1'b0;
    sram_ack = 1'b0;

    // Reset values
    #2;
    chk("rst_sram_req", 64'(sram_req), 64'd0);
    chk("rst_sram_addr", 64'(sram_addr), 64'd0);
    chk("rst_word_idx", 64'(word_idx), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_image_loaded", 64'(image_loaded), 64'd0);
    chk("rst_coef_loaded", 64'(coef_loaded), 64'd0);
    chk("rst_load_is_coef", 64'(load_is_coef), 64'd0);
    chk("rst_bad_bank", 64'(bad_bank), 64'd0);
    step();
    step();
    n_rst = 1'b1;
    step();

    // Ack while idle is ignored; then back-to-back image load with ack held high
    sram_ack = 1'b1;
    step();
    step();
    chk("idle_ack_ignored", 64'(sram_req), 64'd0);
    load_image("img_b2b", 0);

    // Invalid bank: same-cycle pulse, no transfer
    request_coef  = 1'b1;
    coef_bank_sel = 2'd3;
    #1;
    chk("bad_bank_pulse", 64'(bad_bank), 64'd1);
    step();
    request_coef = 1'b0;
    #1;
    chk("bad_bank_low", 64'(bad_bank), 64'd0);
    chk("bad_bank_no_xfer", 64'(busy), 64'd0);
    chk("bad_bank_count", 64'(bad_pulses), 64'd1);

    // Bank 2 with ack on alternate cycles, then bank 1 requested together with done
    load_coef("coef_b2_stall", 2, 1, 1'b0);
    load_coef("coef_b1_prio", 1, 0, 1'b1);
    chk("coef_pulse_count", 64'(coef_pulses), 64'(exp_coef));

    // done_processing -> IDLE, where request_coef is ignored
    done_processing = 1'b1;
    step();
    done_processing = 1'b0;
    request_coef = 1'b1;
    coef_bank_sel = 2'd0;
    step();
    request_coef = 1'b0;
    chk("idle_request_ignored", 64'(busy), 64'd0);

    // Reset during word 2 of an image load
    push_image();
    sram_ack = 1'b1;
    start_detecting = 1'b1;
    step();
    start_detecting = 1'b0;
    step();
    step();
    chk("mid_word_idx", 64'(word_idx), 64'd2);
    sram_ack = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_req", 64'(sram_req), 64'd0);
    chk("mid_rst_addr", 64'(sram_addr), 64'd0);
    chk("mid_rst_idx", 64'(word_idx), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    snap = img_pulses;
    step();
    n_rst = 1'b1;
    step();
    step();
    chk("mid_rst_no_pulse", 64'(img_pulses), 64'(snap));
    chk("mid_rst_idle", 64'(busy), 64'd0);
    load_image("img_restart", 0);

    // Full run with random ack stalls, then reload after done_processing
    done_processing = 1'b1;
    step();
    done_processing = 1'b0;
    load_image("run_img", 2);
    load_coef("run_b0", 0, 2, 1'b0);
    load_coef("run_b1", 1, 2, 1'b0);
    load_coef("run_b0_again", 0, 2, 1'b0);
    done_processing = 1'b1;
    step();
    done_processing = 1'b0;
    chk("run_back_idle", 64'(busy), 64'd0);
    load_image("run_reload", 2);
    chk("img_pulse_total", 64'(img_pulses), 64'(exp_img));
    chk("coef_pulse_total", 64'(coef_pulses), 64'(exp_coef));
    done_processing = 1'b1;
    step();
    done_processing = 1'b0;

`ifdef SRAM_TIMEOUT_EN
    // Ack withheld: ERROR after TIMEOUT_CYCLES request cycles, left via done_processing
    exp_q.push_back({1'b0, 16'd0, 16'(IMAGE_BASE)});
    start_detecting = 1'b1;
    step();
    start_detecting = 1'b0;
    for (int c = 0; c < TIMEOUT_CYCLES; c++) begin
      chk("tmo_req_held", 64'(sram_req), 64'd1);
      chk("tmo_no_error_yet", 64'(error), 64'd0);
      step();
    end
    chk("tmo_error", 64'(error), 64'd1);
    chk("tmo_req_dropped", 64'(sram_req), 64'd0);
    chk("tmo_not_busy", 64'(busy), 64'd0);
    exp_q.delete();
    snap = img_pulses;
    done_processing = 1'b1;
    step();
    done_processing = 1'b0;
    chk("tmo_error_cleared", 64'(error), 64'd0);
    chk("tmo_no_pulse", 64'(img_pulses), 64'(snap));
    load_image("img_after_error", 0);
`else
    // Ack withheld: the word stays requested and error stays low
    push_image();
    start_detecting = 1'b1;
    step();
    start_detecting = 1'b0;
    for (int c = 0; c < 3 * TIMEOUT_CYCLES; c++) begin
      chk("wait_req_held", 64'(sram_req), 64'd1);
      chk("wait_no_error", 64'(error), 64'd0);
      step();
    end
    finish_image("img_after_wait", 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
